button_event_decoder: RTL and testbench

//  Consumes the debounced level from the button debounce stage and converts it into
//  one-cycle event strobes: press, release, single-click, double-click and long-press.

---
 rtl/btn_pkg.sv | 25 ++
 rtl/edge_detect.sv | 34 +++
 rtl/button_event_decoder.sv | 151 +++++++++++++++
 tb/tb_button_event_decoder.sv | 199 +++++++++++++++++++
 4 files changed

// File: rtl/btn_pkg.sv
// ----------------------------------------------------------------------------
// btn_pkg
//   Shared definitions for the button event path.
//   - state_e   : gesture decoder states
//   - CLK_HZ, LONG_MS, DOUBLE_GAP_MS : default timing, converted to cycle
//     counts in DEF_LONG_COUNTS / DEF_DOUBLE_GAP_COUNTS
// ----------------------------------------------------------------------------
package btn_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        PRESS1 = 3'd1,
        GAP    = 3'd2,
        PRESS2 = 3'd3,
        LONG   = 3'd4
    } state_e;

    localparam int unsigned CLK_HZ        = 50_000_000;
    localparam int unsigned LONG_MS       = 1000;
    localparam int unsigned DOUBLE_GAP_MS = 300;

    localparam int unsigned DEF_LONG_COUNTS       = (CLK_HZ / 1000) * LONG_MS;
    localparam int unsigned DEF_DOUBLE_GAP_COUNTS = (CLK_HZ / 1000) * DOUBLE_GAP_MS;

endpackage

// File: rtl/edge_detect.sv
// ----------------------------------------------------------------------------
// edge_detect
//   Registers the previous level and flags rising / falling transitions.
//   Ports:
//     clk_i    in  clock, posedge
//     reset_i  in  synchronous active-high reset (previous level -> 0)
//     level_i  in  synchronised input level
//     rise_o   out level_i & ~prev (combinational)
//     fall_o   out ~level_i & prev (combinational)
//   Clearing prev on reset means a level held high through reset shows up
//   as a rise on the first cycle after reset.
// ----------------------------------------------------------------------------
module edge_detect (
    input  logic clk_i,
    input  logic reset_i,
    input  logic level_i,
    output logic rise_o,
    output logic fall_o
);

    logic prev_q;

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            prev_q <= 1'b0;
        end else begin
            prev_q <= level_i;
        end
    end

    assign rise_o = level_i & ~prev_q;
    assign fall_o = ~level_i & prev_q;

endmodule

// File: rtl/button_event_decoder.sv
// ----------------------------------------------------------------------------
// button_event_decoder
//   Turns the debounced button level into one-cycle gesture strobes.
//   Parameters:
//     LONG_COUNTS        cycles held before long_press (>= 2)
//     DOUBLE_GAP_COUNTS  max released gap between two clicks (>= 2)
//   Ports:
//     clk             in  clock, posedge
//     reset           in  synchronous active-high reset
//     button_pressed  in  debounced level, 1 = pressed
//     press_pulse     out 1-cycle strobe, cycle after every rise
//     release_pulse   out 1-cycle strobe, cycle after every fall
//     single_click    out 1-cycle strobe, short press not followed in time
//     double_click    out 1-cycle strobe, second short press released
//     long_press      out 1-cycle strobe, held LONG_COUNTS cycles
//     long_held       out level, high while in LONG
//   All outputs are registered. state_q is the FSM state register.
// ----------------------------------------------------------------------------
module button_event_decoder
    import btn_pkg::*;
#(
    parameter int unsigned LONG_COUNTS       = DEF_LONG_COUNTS,
    parameter int unsigned DOUBLE_GAP_COUNTS = DEF_DOUBLE_GAP_COUNTS
) (
    input  logic clk,
    input  logic reset,
    input  logic button_pressed,
    output logic press_pulse,
    output logic release_pulse,
    output logic single_click,
    output logic double_click,
    output logic long_press,
    output logic long_held
);

    localparam int unsigned MAX_COUNTS =
        (LONG_COUNTS > DOUBLE_GAP_COUNTS) ? LONG_COUNTS : DOUBLE_GAP_COUNTS;
    localparam int CNT_W = $clog2(MAX_COUNTS) + 1;

    localparam logic [CNT_W-1:0] LONG_LAST = CNT_W'(LONG_COUNTS - 1);
    localparam logic [CNT_W-1:0] GAP_LAST  = CNT_W'(DOUBLE_GAP_COUNTS - 1);
    localparam logic [CNT_W-1:0] CNT_SAT   = '1;

    logic rise;
    logic fall;

    edge_detect u_edge_detect (
        .clk_i   (clk),
        .reset_i (reset),
        .level_i (button_pressed),
        .rise_o  (rise),
        .fall_o  (fall)
    );

    state_e           state_q;
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;
    logic             press_pulse_q;
    logic             release_pulse_q;
    logic             single_click_q;
    logic             double_click_q;
    logic             long_press_q;
    logic             long_held_q;

    // Saturating increment; state entries override this with zero.
    always_comb begin
        cnt_d = cnt_q;
        if (cnt_q != CNT_SAT) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q         <= IDLE;
            cnt_q           <= '0;
            press_pulse_q   <= 1'b0;
            release_pulse_q <= 1'b0;
            single_click_q  <= 1'b0;
            double_click_q  <= 1'b0;
            long_press_q    <= 1'b0;
            long_held_q     <= 1'b0;
        end else begin
            press_pulse_q   <= rise;
            release_pulse_q <= fall;
            single_click_q  <= 1'b0;
            double_click_q  <= 1'b0;
            long_press_q    <= 1'b0;
            cnt_q           <= cnt_d;

            case (state_q)
                IDLE: begin
                    if (rise) begin
                        state_q <= PRESS1;
                        cnt_q   <= '0;
                    end
                end
                PRESS1: begin
                    // A release on the terminal count still counts as short.
                    if (fall) begin
                        state_q <= GAP;
                        cnt_q   <= '0;
                    end else if (cnt_q == LONG_LAST) begin
                        state_q      <= LONG;
                        cnt_q        <= '0;
                        long_press_q <= 1'b1;
                        long_held_q  <= 1'b1;
                    end
                end
                GAP: begin
                    // A second press on the terminal count still makes a double.
                    if (rise) begin
                        state_q <= PRESS2;
                        cnt_q   <= '0;
                    end else if (cnt_q == GAP_LAST) begin
                        state_q        <= IDLE;
                        cnt_q          <= '0;
                        single_click_q <= 1'b1;
                    end
                end
                PRESS2: begin
                    if (fall) begin
                        state_q        <= IDLE;
                        cnt_q          <= '0;
                        double_click_q <= 1'b1;
                    end
                end
                LONG: begin
                    if (fall) begin
                        state_q     <= IDLE;
                        cnt_q       <= '0;
                        long_held_q <= 1'b0;
                    end
                end
                default: begin
                    state_q     <= IDLE;
                    cnt_q       <= '0;
                    long_held_q <= 1'b0;
                end
            endcase
        end
    end

    assign press_pulse   = press_pulse_q;
    assign release_pulse = release_pulse_q;
    assign single_click  = single_click_q;
    assign double_click  = double_click_q;
    assign long_press    = long_press_q;
    assign long_held     = long_held_q;

endmodule

// File: tb/tb_button_event_decoder.sv
// ----------------------------------------------------------------------------
// tb_button_event_decoder
//   Directed gestures with LONG_COUNTS=20, DOUBLE_GAP_COUNTS=10.
//   Each gesture pushes its hand-computed output events, stamped with the
//   clock edge at which they become visible, into exp_q before driving the
//   level. The monitor watches every cycle; whenever a strobe is high or
//   long_held changes, it pops the head of exp_q and compares edge number
//   and the full output vector.
//   Output vector bits: {press, release, single, double, long_press, long_held}
// ----------------------------------------------------------------------------
module tb_button_event_decoder;

    localparam int W = 38;

    localparam logic [5:0] EV_P  = 6'b100000;
    localparam logic [5:0] EV_R  = 6'b010000;
    localparam logic [5:0] EV_S  = 6'b001000;
    localparam logic [5:0] EV_D  = 6'b000100;
    localparam logic [5:0] EV_LP = 6'b000010;
    localparam logic [5:0] EV_LH = 6'b000001;

    logic clk = 1'b0;
    logic reset;
    logic button_pressed;
    logic press_pulse;
    logic release_pulse;
    logic single_click;
    logic double_click;
    logic long_press;
    logic long_held;

    logic [W-1:0] exp_q[$];
    int           cyc = 0;
    int           n_vec = 0;
    int           n_err = 0;
    logic         held_prev = 1'b0;
    logic [5:0]   vec_now;

    assign vec_now = {press_pulse, release_pulse, single_click,
                      double_click, long_press, long_held};

    button_event_decoder #(
        .LONG_COUNTS       (20),
        .DOUBLE_GAP_COUNTS (10)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .button_pressed (button_pressed),
        .press_pulse    (press_pulse),
        .release_pulse  (release_pulse),
        .single_click   (single_click),
        .double_click   (double_click),
        .long_press     (long_press),
        .long_held      (long_held)
    );

    // ---------------- clock / edge counter ----------------
    always #5 clk = ~clk;

    // cyc holds the index of the most recent rising edge.
    always @(posedge clk) cyc <= cyc + 1;

    // ---------------- driver tasks ----------------
    task automatic push(input int c, input logic [5:0] v);
        exp_q.push_back({32'(c), v});
    endtask

    // Hold the level for n sampling edges; returns just after the last one.
    task automatic drive(input logic lvl, input int n);
        button_pressed = lvl;
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // ---------------- monitor / scoreboard ----------------
    always @(negedge clk) begin
        logic [W-1:0] exp_item;
        if ((vec_now[5:1] != 5'b0) || (vec_now[0] != held_prev)) begin
            n_vec++;
            if (exp_q.size() == 0) begin
                n_err++;
                $display("FAIL unexpected_event edge=%0d got=%b required=none", cyc, vec_now);
            end else begin
                exp_item = exp_q.pop_front();
                if ({32'(cyc), vec_now} != exp_item) begin
                    n_err++;
                    $display("FAIL event_check got edge=%0d vec=%b required edge=%0d vec=%b",
                             cyc, vec_now, exp_item[W-1:6], exp_item[5:0]);
                end
            end
        end
        held_prev = vec_now[0];
    end

    // ---------------- stimulus ----------------
    initial begin
        int k;
        reset          = 1'b1;
        button_pressed = 1'b0;

        // 1. reset with level low: outputs quiet during and after reset
        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            @(negedge clk);
            n_vec++;
            if (vec_now !== 6'b0) begin
                n_err++;
                $display("FAIL reset_outputs got=%b required=000000", vec_now);
            end
        end
        reset = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            n_vec++;
            if (vec_now !== 6'b0) begin
                n_err++;
                $display("FAIL post_reset_outputs got=%b required=000000", vec_now);
            end
        end
        @(posedge clk);
        #1;

        // 2. single click: high 5, low 15
        k = cyc + 1;
        push(k, EV_P);
        push(k + 5, EV_R);
        push(k + 15, EV_S);
        drive(1'b1, 5);
        drive(1'b0, 15);

        // 3. double click: high 5, low 4, high 5, low
        k = cyc + 1;
        push(k, EV_P);
        push(k + 5, EV_R);
        push(k + 9, EV_P);
        push(k + 14, EV_R | EV_D);
        drive(1'b1, 5);
        drive(1'b0, 4);
        drive(1'b1, 5);
        drive(1'b0, 15);

        // 4. long press: high 30
        k = cyc + 1;
        push(k, EV_P);
        push(k + 20, EV_LP | EV_LH);
        push(k + 30, EV_R);
        drive(1'b1, 30);
        drive(1'b0, 15);

        // 5a. boundary: high exactly 20 -> short press, single click
        k = cyc + 1;
        push(k, EV_P);
        push(k + 20, EV_R);
        push(k + 30, EV_S);
        drive(1'b1, 20);
        drive(1'b0, 15);

        // 5b. boundary: high 21 -> long press
        k = cyc + 1;
        push(k, EV_P);
        push(k + 20, EV_LP | EV_LH);
        push(k + 21, EV_R);
        drive(1'b1, 21);
        drive(1'b0, 15);

        // 6. reset at GAP counter=5, button held high across reset release
        k = cyc + 1;
        push(k, EV_P);
        push(k + 5, EV_R);
        push(k + 14, EV_P);
        push(k + 18, EV_R);
        push(k + 28, EV_S);
        drive(1'b1, 5);
        drive(1'b0, 6);
        reset = 1'b1;
        drive(1'b1, 3);
        reset = 1'b0;
        drive(1'b1, 4);
        drive(1'b0, 15);

        // drain: anything still expected never appeared
        repeat (5) @(posedge clk);
        @(negedge clk);
        while (exp_q.size() != 0) begin
            logic [W-1:0] miss;
            miss = exp_q.pop_front();
            n_vec++;
            n_err++;
            $display("FAIL missing_event got=none required edge=%0d vec=%b",
                     miss[W-1:6], miss[5:0]);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
